// File: rtl/pushbutton_service_ctrl_if.sv
// Bus bundle for the pushbutton service sequencer: PIO slave-port access
// plus the timestamped event valid/ready channel.
interface pushbutton_service_ctrl_if #(
  parameter int TS_WIDTH = 16
);
  logic [1:0]           pio_address;
  logic                 pio_chipselect;
  logic                 pio_write_n;
  logic [31:0]          pio_writedata;
  logic [31:0]          pio_readdata;
  logic                 pio_irq;
  logic                 evt_valid;
  logic [TS_WIDTH+3:0]  evt_data;
  logic                 evt_ready;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq,
    output evt_valid, evt_data,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output pio_readdata, pio_irq,
    input  evt_valid, evt_data,
    output evt_ready
  );
endinterface

// File: rtl/pushbutton_service_ctrl.sv
// Services the 4-bit pushbutton PIO in hardware: programs irq_mask, reads and
// clears edge_capture on irq, and queues {timestamp, buttons} in a FWFT FIFO.
module pushbutton_service_ctrl #(
  parameter logic [3:0] INIT_MASK      = 4'hF,
  parameter int         TS_WIDTH       = 16,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         LOCKOUT_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pushbutton_service_ctrl_if.master   bus,
  input  logic                        cfg_mask_req,
  input  logic [3:0]                  cfg_mask,
  output logic                        overflow,
  output logic                        busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [3:0]          btn;
  } evt_t;

  typedef enum logic [2:0] {
    S_RST, S_INIT, S_IDLE, S_MASK, S_RD, S_CAP, S_PUSH, S_LOCK
  } state_t;

  state_t               state, state_nx;
  logic [TS_WIDTH-1:0]  ts, stamp;
  logic [3:0]           cap, mask_reg;
  logic                 mask_pending;
  logic [LW-1:0]        lock_cnt;
  evt_t                 mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 ovf;

  logic [1:0]           addr;
  logic                 cs, wn;
  logic [31:0]          wd;
  logic                 push, pop, drop, full;
  logic                 unused_rd;

  assign unused_rd = ^bus.pio_readdata[31:4];
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign pop       = bus.evt_valid & bus.evt_ready;

  always_comb begin
    state_nx = state;
    addr     = 2'd0;
    cs       = 1'b0;
    wn       = 1'b1;
    wd       = 32'd0;
    push     = 1'b0;
    drop     = 1'b0;
    case (state)
      S_RST:  state_nx = S_INIT;
      S_INIT: begin
        cs = 1'b1; wn = 1'b0; addr = 2'd2; wd = {28'd0, INIT_MASK};
        state_nx = S_IDLE;
      end
      S_IDLE: begin
        // a request arriving this very cycle already outranks irq
        if (mask_pending || cfg_mask_req) state_nx = S_MASK;
        else if (bus.pio_irq)             state_nx = S_RD;
      end
      S_MASK: begin
        cs = 1'b1; wn = 1'b0; addr = 2'd2; wd = {28'd0, mask_reg};
        state_nx = S_IDLE;
      end
      S_RD: begin
        cs = 1'b1; addr = 2'd3;
        state_nx = S_CAP;
      end
      S_CAP: begin
        cs = 1'b1; wn = 1'b0; addr = 2'd3;
        state_nx = S_PUSH;
      end
      S_PUSH: begin
        if (cap != 4'd0) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
        end
        state_nx = S_LOCK;
      end
      S_LOCK: if (lock_cnt == '0) state_nx = S_IDLE;
      default: state_nx = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_RST;
      ts           <= '0;
      stamp        <= '0;
      cap          <= '0;
      mask_reg     <= '0;
      mask_pending <= 1'b0;
      lock_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
    end else begin
      state <= state_nx;
      ts    <= ts + 1'b1;
      if (cfg_mask_req) begin
        mask_reg     <= cfg_mask;
        mask_pending <= 1'b1;
      end else if (state == S_MASK) begin
        mask_pending <= 1'b0;
      end
      // stamp marks the cycle the read is issued; readdata lands in CAP
      if (state == S_RD)  stamp <= ts;
      if (state == S_CAP) cap   <= bus.pio_readdata[3:0];
      if (state == S_PUSH)      lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
      else if (state == S_LOCK) lock_cnt <= lock_cnt - 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ts: stamp, btn: cap};
  end

  assign bus.pio_address    = addr;
  assign bus.pio_chipselect = cs;
  assign bus.pio_write_n    = wn;
  assign bus.pio_writedata  = wd;
  assign bus.evt_valid      = (count != '0);
  assign bus.evt_data       = mem[rd_ptr];
  assign overflow           = ovf;
  assign busy               = (state != S_IDLE);
endmodule
